// File: rtl/cell_s_pkg.sv
// cell_s_pkg: shared opcodes, instruction layout and FSM encodings for the cell sequencer
package cell_s_pkg;
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;
  localparam int INSTR_W = 9;
  localparam int BYP_B = 8;
  localparam int SEL0_MSB = 7;
  localparam int SEL0_LSB = 6;
  localparam int SEL1_MSB = 5;
  localparam int SEL1_LSB = 4;
  localparam int OP_MSB = 3;
  localparam int OP_LSB = 2;
  localparam int DST_MSB = 1;
  localparam int DST_LSB = 0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;
  typedef struct packed {
    logic bypass;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic [1:0] selop;
    logic [1:0] dst;
  } instr_t;
  function automatic instr_t decode(logic [INSTR_W-1:0] w);
    instr_t i;
    i.bypass = w[BYP_B];
    i.sel0 = w[SEL0_MSB:SEL0_LSB];
    i.sel1 = w[SEL1_MSB:SEL1_LSB];
    i.selop = w[OP_MSB:OP_LSB];
    i.dst = w[DST_MSB:DST_LSB];
    return i;
  endfunction
endpackage

// File: rtl/cell_s_sequencer_if.sv
// cell_s_sequencer_if: host handshakes plus the loop to the external shifter/XOR cell
interface cell_s_sequencer_if #(parameter int WIDTH = 32, parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic load_valid;
  logic load_ready;
  logic [1:0] load_addr;
  logic [WIDTH-1:0] load_data;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [8:0] prog_data;
  logic start;
  logic [AW:0] len;
  logic busy;
  logic result_valid;
  logic result_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] cell_in0, cell_in1, cell_in2, cell_in3;
  logic [1:0] cell_sel0, cell_sel1, cell_selop;
  logic cell_bypass;
  logic [WIDTH-1:0] cell_out;
  modport master (
    output load_valid, load_addr, load_data, prog_we, prog_addr, prog_data, start, len, result_ready, cell_out,
    input load_ready, busy, result_valid, result, cell_in0, cell_in1, cell_in2, cell_in3,
    input cell_sel0, cell_sel1, cell_selop, cell_bypass
  );
  modport slave (
    input load_valid, load_addr, load_data, prog_we, prog_addr, prog_data, start, len, result_ready, cell_out,
    output load_ready, busy, result_valid, result, cell_in0, cell_in1, cell_in2, cell_in3,
    output cell_sel0, cell_sel1, cell_selop, cell_bypass
  );
endinterface

// File: rtl/cell_s_prog_mem.sv
// cell_s_prog_mem: DEPTH x 9 micro-program store, synchronous write, combinational read
module cell_s_prog_mem import cell_s_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cell_s_sequencer.sv
// cell_s_sequencer: operand bank and micro-program sequencer closing the loop around the cell
module cell_s_sequencer import cell_s_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  cell_s_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [AW-1:0] pc;
  logic [AW:0] len_q, len_c;
  logic [WIDTH-1:0] r [4];
  logic [WIDTH-1:0] res_q, r0_new;
  logic [INSTR_W-1:0] rd;
  instr_t ins;
  logic idle, exec, last;
  cell_s_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(bus.prog_we && idle), .waddr(bus.prog_addr), .wdata(bus.prog_data),
    .raddr(pc), .rdata(rd)
  );
  assign ins = decode(rd);
  assign idle = state == ST_IDLE;
  assign exec = state == ST_EXEC;
  assign len_c = bus.len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.len;
  assign last = (AW+1)'(pc) + 1'b1 == len_q;
  // a same-cycle load to R0 must be visible to a zero-length program
  assign r0_new = bus.load_valid && bus.load_addr == 2'd0 ? bus.load_data : r[0];
  always_ff @(posedge clk) state <= reset ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = idle ? (bus.start ? (len_c == '0 ? ST_RESP : ST_EXEC) : ST_IDLE)
             : exec ? (last ? ST_RESP : ST_EXEC)
             : (bus.result_ready ? ST_IDLE : ST_RESP);
  end
  always_comb begin
    bus.load_ready = idle;
    bus.busy = !idle;
    bus.result_valid = state == ST_RESP;
    bus.result = res_q;
    bus.cell_sel0 = exec ? ins.sel0 : 2'd0;
    bus.cell_sel1 = exec ? ins.sel1 : 2'd0;
    bus.cell_selop = exec ? ins.selop : OP_SLL;
    bus.cell_bypass = exec && ins.bypass;
    bus.cell_in0 = r[0];
    bus.cell_in1 = r[1];
    bus.cell_in2 = r[2];
    bus.cell_in3 = r[3];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      len_q <= '0;
      res_q <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else if (idle) begin
      if (bus.load_valid) r[bus.load_addr] <= bus.load_data;
      if (bus.start) begin
        pc <= '0;
        len_q <= len_c;
        if (len_c == '0) res_q <= r0_new;
      end
    end else if (exec) begin
      r[ins.dst] <= bus.cell_out;
      pc <= pc + 1'b1;
      if (last) res_q <= bus.cell_out;
    end
  end
endmodule

// File: tb/tb_cell_s_sequencer.sv
// tb_cell_s_sequencer: table vectors, corner sequences and random programs against a program-level model
module tb_cell_s_sequencer;
  import cell_s_pkg::*;
  logic clk = 0;
  logic reset;
  int n_cmp = 0, n_bad = 0;
  cell_s_sequencer_if #(.WIDTH(32), .DEPTH(8)) bus();
  cell_s_sequencer #(.WIDTH(32), .DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] cell_f(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic byp);
    logic [4:0] s;
    s = b[4:0];
    if (byp) return a;
    case (op)
      OP_SLL: return a << s;
      OP_SRL: return a >> s;
      OP_SRA: return $unsigned($signed(a) >>> s);
      default: return a ^ b;
    endcase
  endfunction
  logic [31:0] cin [4];
  assign cin[0] = bus.cell_in0;
  assign cin[1] = bus.cell_in1;
  assign cin[2] = bus.cell_in2;
  assign cin[3] = bus.cell_in3;
  assign bus.cell_out = cell_f(cin[bus.cell_sel0], cin[bus.cell_sel1], bus.cell_selop, bus.cell_bypass);
  logic [31:0] mr [4];
  logic [8:0] mm [8];
  function automatic logic [31:0] model_run(int n);
    logic [31:0] res;
    logic [8:0] w;
    res = mr[0];
    for (int i = 0; i < (n > 8 ? 8 : n); i++) begin
      w = mm[i];
      res = cell_f(mr[w[7:6]], mr[w[5:4]], w[3:2], w[8]);
      mr[w[1:0]] = res;
    end
    return res;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic load(input int a, input logic [31:0] d);
    bus.load_valid = 1;
    bus.load_addr = a[1:0];
    bus.load_data = d;
    tick;
    bus.load_valid = 0;
    mr[a] = d;
  endtask
  task automatic prog(input int a, input logic [8:0] d);
    bus.prog_we = 1;
    bus.prog_addr = a[2:0];
    bus.prog_data = d;
    tick;
    bus.prog_we = 0;
    mm[a] = d;
  endtask
  task automatic run(input int n, input logic [31:0] exp, input int hold, input string nm);
    int lat;
    logic [31:0] held;
    bus.start = 1;
    bus.len = 4'(n);
    tick;
    bus.start = 0;
    chk({nm, " busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.result_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk({nm, " latency"}, lat, n > 8 ? 8 : n);
    chk({nm, " result"}, bus.result, exp);
    held = bus.result;
    repeat (hold) begin
      tick;
      chk({nm, " valid held"}, 32'(bus.result_valid), 32'd1);
      chk({nm, " result held"}, bus.result, held);
    end
    bus.result_ready = 1;
    tick;
    bus.result_ready = 0;
    chk({nm, " valid drop"}, 32'(bus.result_valid), 32'd0);
    chk({nm, " load_ready"}, 32'(bus.load_ready), 32'd1);
  endtask
  function automatic logic [31:0] regv(int i);
    return i == 0 ? bus.cell_in0 : i == 1 ? bus.cell_in1 : i == 2 ? bus.cell_in2 : bus.cell_in3;
  endfunction
  typedef struct {
    logic [31:0] r0, r1, r2, r3;
    logic [8:0] i0, i1;
    int n;
    logic [31:0] res;
    int dreg;
    logic [31:0] dval;
  } vec_t;
  vec_t tbl [6];
  initial begin
    logic [31:0] e;
    tbl[0] = '{32'h1, 32'h4, 32'h0, 32'h0, 9'h012, 9'h000, 1, 32'h10, 2, 32'h10};
    tbl[1] = '{32'h80000000, 32'h24, 32'h0, 32'h0, 9'h01B, 9'h000, 1, 32'hF8000000, 3, 32'hF8000000};
    tbl[2] = '{32'hFF00FF00, 32'h0F0F0F0F, 32'h8, 32'h0, 9'h01C, 9'h024, 2, 32'h00F00FF0, 0, 32'h00F00FF0};
    tbl[3] = '{32'h0, 32'h0, 32'h0, 32'h12345678, 9'h1C1, 9'h000, 1, 32'h12345678, 1, 32'h12345678};
    tbl[4] = '{32'h0, 32'h1F, 32'h1, 32'h0, 9'h090, 9'h000, 1, 32'h80000000, 0, 32'h80000000};
    tbl[5] = '{32'hDEADBEEF, 32'h20, 32'h0, 32'h0, 9'h015, 9'h000, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF};
    bus.load_valid = 0; bus.load_addr = 0; bus.load_data = 0;
    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    bus.start = 0; bus.len = 0; bus.result_ready = 0;
    for (int i = 0; i < 4; i++) mr[i] = 0;
    reset = 1;
    tick;
    tick;
    reset = 0;
    chk("rst load_ready", 32'(bus.load_ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst valid", 32'(bus.result_valid), 32'd0);
    chk("rst result", bus.result, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst R%0d", i), regv(i), 32'd0);
    chk("rst ctrl", 32'({bus.cell_sel0, bus.cell_sel1, bus.cell_selop, bus.cell_bypass}), 32'd0);
    for (int k = 0; k < 6; k++) begin
      load(0, tbl[k].r0); load(1, tbl[k].r1); load(2, tbl[k].r2); load(3, tbl[k].r3);
      prog(0, tbl[k].i0); prog(1, tbl[k].i1);
      run(tbl[k].n, tbl[k].res, 0, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d dst", k), regv(tbl[k].dreg), tbl[k].dval);
    end
    // zero-length program, then everything poked while busy must be ignored
    load(0, 32'hA5A5A5A5);
    bus.start = 1; bus.len = 0;
    tick;
    bus.start = 0;
    chk("len0 valid", 32'(bus.result_valid), 32'd1);
    chk("len0 result", bus.result, 32'hA5A5A5A5);
    chk("busy load_ready", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1; bus.load_addr = 0; bus.load_data = 32'h0;
    bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 9'h1C3;
    bus.start = 1; bus.len = 1;
    tick;
    bus.load_valid = 0; bus.prog_we = 0; bus.start = 0;
    chk("busy load ignored", bus.cell_in0, 32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) begin
      chk("hold valid", 32'(bus.result_valid), 32'd1);
      chk("hold result", bus.result, 32'hA5A5A5A5);
      tick;
    end
    bus.result_ready = 1;
    tick;
    bus.result_ready = 0;
    chk("accept valid", 32'(bus.result_valid), 32'd0);
    chk("accept load_ready", 32'(bus.load_ready), 32'd1);
    chk("accept busy", 32'(bus.busy), 32'd0);
    load(1, 32'h4);
    e = model_run(1);
    run(1, e, 0, "prog ignored");
    bus.load_valid = 1; bus.load_addr = 0; bus.load_data = 32'h5555AAAA;
    bus.start = 1; bus.len = 0;
    tick;
    bus.load_valid = 0; bus.start = 0;
    mr[0] = 32'h5555AAAA;
    chk("load+start result", bus.result, 32'h5555AAAA);
    bus.result_ready = 1;
    tick;
    bus.result_ready = 0;
    prog(0, 9'h01C); prog(1, 9'h095); prog(2, 9'h1E2); prog(3, 9'h06B);
    load(0, 32'h11); load(1, 32'h3); load(2, 32'hF0F0); load(3, 32'h7);
    bus.start = 1; bus.len = 4;
    tick;
    bus.start = 0;
    tick;
    chk("mid exec busy", 32'(bus.busy), 32'd1);
    reset = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 4; i++) mr[i] = 0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort valid", 32'(bus.result_valid), 32'd0);
    chk("abort result", bus.result, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("abort R%0d", i), regv(i), 32'd0);
    load(0, 32'h11); load(1, 32'h3); load(2, 32'hF0F0); load(3, 32'h7);
    e = model_run(4);
    run(4, e, 0, "after abort");
    for (int i = 0; i < 8; i++) prog(i, 9'($urandom));
    for (int it = 0; it < 40; it++) begin
      int n;
      repeat ($urandom_range(0, 4)) load($urandom_range(0, 3), $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40));
      repeat ($urandom_range(0, 3)) prog($urandom_range(0, 7), 9'($urandom));
      n = $urandom_range(0, 15);
      e = model_run(n);
      run(n, e, $urandom_range(0, 2), $sformatf("rnd%0d", it));
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d R%0d", it, i), regv(i), mr[i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
